uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Transmit-side counterpart of the receive chain (receiver -> byte buffer).
- Accepts bytes from the encoding/decoding stages through a small FIFO and serializes them as UART frames on bit_out.
- Uses the same oversampled bit period as the receive side, so its output can be looped straight back into the receiver.
- Absorbs back-to-back result bytes, so upstream stages no longer need to stall on a transmitter busy signal.

Parameters:
- CLKS_PER_BIT, 4: clock cycles per serial bit (start, data and stop bits).
- DEPTH, 4: FIFO depth in bytes; power of two, at least 2.
- MSB_FIRST, 1: 1 = data bit 7 is sent first; 0 = bit 0 is sent first.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
- enable  in  1  write strobe; byte_in is written when enable=1 and full=0.
- byte_in  in  8  byte to transmit.
- bit_out  out  1  serial line; idles high.
- busy  out  1  1 while the FIFO is non-empty or a frame is in progress.
- full  out  1  FIFO holds DEPTH bytes.
- level  out  $clog2(DEPTH)+1  number of bytes stored in the FIFO.
- overflow  out  1  one-cycle pulse when enable=1 arrives while full=1 with no pop in the same cycle; the byte is dropped.

Behaviour:
- Reset (reset=0 at an edge): on the next edge bit_out=1, busy=0, full=0, level=0, overflow=0, FSM=IDLE, FIFO pointers cleared.
- Reset mid-frame aborts the frame and flushes the FIFO; bit_out returns high on that same edge.
- FIFO:
  - Circular buffer with read/write pointers plus a count.
  - Write and pop in the same cycle: level is unchanged. When full, the simultaneous pop frees the slot, so the write is accepted and no overflow pulse is generated.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: bit_out=1. If level>0 at an edge: pop the head byte into the shift register, clear the bit counter and sub-bit counter, go to START.
  - START: bit_out=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: present 8 bits, each for CLKS_PER_BIT cycles. Order is MSB-first when MSB_FIRST=1, otherwise LSB-first. After the 8th bit, go to STOP.
  - STOP: bit_out=1 for STOP_BITS*CLKS_PER_BIT cycles. On the last STOP cycle:
    - if level>0, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Outputs:
  - bit_out is registered and glitch-free.
  - Frame length is (1+8+STOP_BITS)*CLKS_PER_BIT cycles.
- Latency: enable at edge N with the FIFO empty and FSM in IDLE -> pop at edge N+1 -> bit_out=0 from edge N+1 for CLKS_PER_BIT cycles. The popped byte does not count in level.
- busy = (state != IDLE) | (level != 0); combinational from registers.
- Counters: the sub-bit counter is $clog2(CLKS_PER_BIT) bits wide and wraps at CLKS_PER_BIT-1; the bit counter is 3 bits wide.
- A write arriving while a frame is in progress does not disturb the shift register.

Decomposition:
- Shared UART package:
  - tx state enum (IDLE, START, DATA, STOP);
  - default constants CLKS_PER_BIT=4 and frame data width 8, shared with the receiver.
- One sub-module: uart_tx_fifo_mem (parameterised synchronous FIFO with level/full/empty and a same-cycle read+write rule).
- FSM and shifter stay in the top module.

Test Plan:
- Reset check: hold reset=0 for 3 cycles -> bit_out=1, busy=0, level=0. Release reset, idle 20 cycles -> bit_out remains 1.
- Single byte 8'b00110001, MSB_FIRST=1: pulse enable -> bit_out sequence, 4 cycles per symbol, is 0 | 0,0,1,1,0,0,0,1 | 1. busy falls 40 cycles after the pop.
- Back-to-back: write 8'hAA, 8'h00, 8'h31 on consecutive cycles -> level peaks at 2, then three 40-cycle frames with no idle cycles between them, then busy=0.
- Overflow: DEPTH=4, write 6 bytes in consecutive cycles starting from idle (first pops at once) -> 5 accepted. full=1 from the 5th write; overflow pulses exactly once on the 6th write; that byte is never transmitted.
- Reset mid-frame: assert reset during bit 3 of a frame with 2 bytes queued -> next edge bit_out=1, level=0, busy=0, and no further frames.
- Loopback: bit_out -> UART receiver with matching oversampling, bytes 8'h31, 8'h00, 8'h00, 8'h31 -> the receiver reports the same 4 bytes in order, each with ready asserted.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: transmitter state encoding and default framing constants.
package uart_tx_fifo_pkg;

   localparam int UART_CLKS_PER_BIT = 4;
   localparam int UART_DATA_W       = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Synchronous circular-buffer FIFO with occupancy count.
// The head entry is always visible on rd_data; a pop in the same cycle as a
// write to a full FIFO frees the slot, so the write is accepted.
module uart_tx_fifo_mem
   import uart_tx_fifo_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = UART_DATA_W,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [LW-1:0]    level,
   output logic             full,
   output logic             empty,
   output logic             overflow
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    count_q, count_d;
   logic             overflow_q;
   logic             push, pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == LW'(DEPTH));
   assign level    = count_q;
   assign overflow = overflow_q;
   assign rd_data  = mem_q[rd_ptr_q];

   // Accept/pop qualification and next occupancy.
   always_comb begin
      pop  = rd_en & ~empty;
      push = wr_en & (~full | pop);
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointers, count and overflow pulse; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q    <= count_d;
         overflow_q <= wr_en & full & ~pop;
      end
   end

   // Storage array; contents need no reset since the count gates every read.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from a small byte FIFO.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | 8 data bits, CLKS_PER_BIT cycles each
// STOP  | STOP_BITS stop bits (high); pops the next byte on its last cycle
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int DEPTH        = 4,
   parameter int MSB_FIRST    = 1,
   parameter int STOP_BITS    = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [7:0]             byte_in,
   output logic                   bit_out,
   output logic                   busy,
   output logic                   full,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow
);

   localparam int              SUB_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

   tx_state_e        state_q, state_d;
   logic [7:0]       shift_q, shift_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
   logic             bit_out_q, bit_out_d;
   logic             pop, empty, sub_end;
   logic [7:0]       head;

   uart_tx_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_mem (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (enable),
      .wr_data  (byte_in),
      .rd_en    (pop),
      .rd_data  (head),
      .level    (level),
      .full     (full),
      .empty    (empty),
      .overflow (overflow)
   );

   assign sub_end = (sub_cnt_q == SUB_LAST);
   assign bit_out = bit_out_q;
   assign busy    = (state_q != IDLE) | (level != '0);

   // Next state, shifter and the registered line value; the line is computed
   // one cycle ahead so bit_out comes straight from a flop.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      bit_out_d = bit_out_q;
      pop       = 1'b0;
      sub_cnt_d = sub_end ? '0 : sub_cnt_q + 1'b1;
      case (state_q)
         IDLE: begin
            sub_cnt_d = '0;
            bit_out_d = 1'b1;
            if (!empty) begin
               pop       = 1'b1;
               shift_d   = head;
               bit_cnt_d = '0;
               state_d   = START;
               bit_out_d = 1'b0;
            end
         end
         START: begin
            if (sub_end) begin
               state_d   = DATA;
               bit_cnt_d = '0;
               bit_out_d = (MSB_FIRST != 0) ? shift_q[7] : shift_q[0];
            end
         end
         DATA: begin
            if (sub_end) begin
               if (bit_cnt_q == 3'd7) begin
                  state_d   = STOP;
                  bit_cnt_d = '0;
                  bit_out_d = 1'b1;
               end else begin
                  shift_d   = (MSB_FIRST != 0) ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  bit_out_d = (MSB_FIRST != 0) ? shift_d[7] : shift_d[0];
               end
            end
         end
         STOP: begin
            if (sub_end) begin
               if (bit_cnt_q == STOP_LAST) begin
                  if (!empty) begin
                     pop       = 1'b1;
                     shift_d   = head;
                     bit_cnt_d = '0;
                     state_d   = START;
                     bit_out_d = 1'b0;
                  end else begin
                     state_d   = IDLE;
                     bit_out_d = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            bit_out_d = 1'b1;
         end
      endcase
   end

   // State and datapath registers; reset aborts any frame with the line high.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         sub_cnt_q <= '0;
         bit_out_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         sub_cnt_q <= sub_cnt_d;
         bit_out_q <= bit_out_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a frame-timeline reference model
// predicts every output each cycle, and a behavioural receiver decodes the
// serial line so delivered bytes can be compared with completed frames.
module tb_uart_tx_fifo;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;
   localparam int FRAME = (1 + 8 + 1) * CPB;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic [7:0]    byte_in = 8'h00;
   logic          bit_out, busy, full, overflow;
   logic [LW-1:0] level;

   always #5 clk = ~clk;

   uart_tx_fifo #(
      .CLKS_PER_BIT (CPB),
      .DEPTH        (DEPTH),
      .MSB_FIRST    (1),
      .STOP_BITS    (1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .byte_in  (byte_in),
      .bit_out  (bit_out),
      .busy     (busy),
      .full     (full),
      .level    (level),
      .overflow (overflow)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: queued bytes, and the position inside the current frame.
   logic [7:0] m_q[$];
   logic [7:0] m_done[$];
   bit         m_active = 1'b0;
   logic [7:0] m_cur = 8'h00;
   int         m_t = 0;
   bit         m_ovf = 1'b0;

   int peak_level = 0;
   int ovf_seen = 0;

   // Behavioural receiver with the same oversampling, MSB first.
   logic [7:0] rx_q[$];
   bit         rx_act = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_sh = 8'h00;
   int         rx_bad_stop = 0;

   always @(posedge clk) begin
      if (!reset) begin
         rx_act <= 1'b0;
         rx_cnt <= 0;
      end else if (!rx_act) begin
         if (bit_out == 1'b0) begin
            rx_act <= 1'b1;
            rx_cnt <= 1;
         end
      end else begin
         if (rx_cnt % CPB == CPB / 2) begin
            if (rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8)
               rx_sh <= {rx_sh[6:0], bit_out};
            if (rx_cnt / CPB == 9) begin
               if (bit_out == 1'b1) rx_q.push_back(rx_sh);
               else                 rx_bad_stop++;
               rx_act <= 1'b0;
            end
         end
         rx_cnt <= rx_cnt + 1;
      end
   end

   function automatic logic exp_bit();
      int idx;
      if (!m_active) return 1'b1;
      idx = m_t / CPB;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return m_cur[8 - idx];
      return 1'b1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic rst_n, input logic en, input logic [7:0] b);
      bit         last, pop;
      logic [7:0] hd;
      reset   = rst_n;
      enable  = en;
      byte_in = b;
      @(posedge clk);
      if (!rst_n) begin
         m_q.delete();
         m_active = 1'b0;
         m_t      = 0;
         m_ovf    = 1'b0;
      end else begin
         last = m_active && (m_t == FRAME - 1);
         pop  = (!m_active || last) && (m_q.size() > 0);
         hd   = 8'h00;
         if (last) m_done.push_back(m_cur);
         if (pop)  hd = m_q.pop_front();
         m_ovf = 1'b0;
         if (en) begin
            if (m_q.size() < DEPTH) m_q.push_back(b);
            else                    m_ovf = 1'b1;
         end
         if (pop) begin
            m_active = 1'b1;
            m_t      = 0;
            m_cur    = hd;
         end else if (last) begin
            m_active = 1'b0;
         end else if (m_active) begin
            m_t++;
         end
      end
      #1;
      check("bit_out",  32'(bit_out),  32'(exp_bit()));
      check("level",    32'(level),    32'(m_q.size()));
      check("full",     32'(full),     32'(m_q.size() == DEPTH));
      check("busy",     32'(busy),     32'(m_active || m_q.size() > 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (int'(level) > peak_level) peak_level = int'(level);
      if (overflow) ovf_seen++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 8'h00);
   endtask

   initial begin
      int         rx_before;
      logic [7:0] loop_bytes [4];
      logic [7:0] rb;
      bit         dropped_seen;

      // Reset held for three cycles, then a quiet idle line.
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00);
      check("rst_bit_out", 32'(bit_out), 32'd1);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_level",   32'(level),   32'd0);
      idle(20);

      // Single byte.
      tick(1'b1, 1'b1, 8'b0011_0001);
      idle(FRAME + 5);

      // Back-to-back writes.
      peak_level = 0;
      tick(1'b1, 1'b1, 8'hAA);
      tick(1'b1, 1'b1, 8'h00);
      tick(1'b1, 1'b1, 8'h31);
      idle(3 * FRAME + 5);
      check("bb_peak_level", 32'(peak_level), 32'd2);

      // Overflow: six writes from idle, the last one is dropped.
      ovf_seen = 0;
      for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 8'(8'h10 + i));
      check("ovf_pulses", 32'(ovf_seen), 32'd1);
      idle(5 * FRAME + 5);
      dropped_seen = 1'b0;
      foreach (rx_q[i]) if (rx_q[i] == 8'h15) dropped_seen = 1'b1;
      check("ovf_byte_dropped", 32'(dropped_seen), 32'd0);

      // Reset during data bit 3 with two bytes queued.
      tick(1'b1, 1'b1, 8'hC3);
      tick(1'b1, 1'b1, 8'h5A);
      tick(1'b1, 1'b1, 8'h0F);
      idle(14);
      rx_before = rx_q.size();
      tick(1'b0, 1'b0, 8'h00);
      check("mid_rst_bit_out", 32'(bit_out), 32'd1);
      check("mid_rst_level",   32'(level),   32'd0);
      check("mid_rst_busy",    32'(busy),    32'd0);
      idle(2 * FRAME);
      check("mid_rst_no_frames", 32'(rx_q.size()), 32'(rx_before));

      // Loopback of four bytes into the receiver.
      loop_bytes[0] = 8'h31;
      loop_bytes[1] = 8'h00;
      loop_bytes[2] = 8'h00;
      loop_bytes[3] = 8'h31;
      rx_before = rx_q.size();
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, loop_bytes[i]);
      idle(4 * FRAME + 10);
      check("loop_count", 32'(rx_q.size() - rx_before), 32'd4);
      for (int i = 0; i < 4; i++) begin
         rb = (rx_before + i < rx_q.size()) ? rx_q[rx_before + i] : 8'hxx;
         check($sformatf("loop_byte%0d", i), 32'(rb), 32'(loop_bytes[i]));
      end

      // Random traffic: a dense burst phase, then a sparse phase.
      for (int i = 0; i < 300; i++)
         tick(1'b1, 1'($urandom_range(0, 2) == 0), 8'($urandom));
      for (int i = 0; i < 400; i++)
         tick(1'b1, 1'($urandom_range(0, 39) == 0), 8'($urandom));
      idle((DEPTH + 1) * FRAME + 10);

      // Every completed frame must have been received intact and in order.
      check("rx_total", 32'(rx_q.size()), 32'(m_done.size()));
      check("rx_bad_stop", 32'(rx_bad_stop), 32'd0);
      for (int i = 0; i < m_done.size() && i < rx_q.size(); i++)
         check($sformatf("rx_byte%0d", i), 32'(rx_q[i]), 32'(m_done[i]));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
